code_step_sequencer: RTL and testbench
======================================

Name: code_step_sequencer

Overview:
Sequential source of the 3-bit code that feeds the binary/Gray code encoder stage; the encoder consumes code_out directly.
- Advances the code one step every DIV clocks while running.
- Supports wrap-up, wrap-down, ping-pong and single-shot sweep modes, plus synchronous load, start/stop control, and step and terminal-count strobes for downstream logic.

Parameters:
DIV, 4, clock cycles per code step; legal range 1..256; DIV=1 steps every clock.
CODE_MAX, 7, top code value; fixed at 7 to match the encoder's 3-bit input.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  level-sampled; IDLE/DONE -> RUN; also latches mode.
stop  input  1  RUN -> IDLE; code_out holds.
mode  input  2  00 wrap-up, 01 wrap-down, 10 ping-pong, 11 single-shot up; sampled only on accepted start.
load  input  1  synchronous load of load_val into code_out, any state.
load_val  input  3  value for load.
code_out  output  3  current code, drives encoder input.
busy  output  1  high in RUN.
step  output  1  one-cycle strobe on the cycle code_out changes due to a step (not load).
tc  output  1  one-cycle strobe when a step lands on a terminal value.

Behaviour:
- Reset (async, any time, including mid-sweep):
  - code_out=0, state=IDLE, busy=0, step=0, tc=0, prescaler=0, direction=up, latched mode=00.
- States:
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop.
  - RUN -> DONE when single-shot reaches CODE_MAX.
  - DONE -> RUN on start.
- Precedence:
  - start and stop in the same cycle: stop wins; stay or go IDLE.
  - load has priority over a step in the same cycle: code_out=load_val, prescaler cleared, no step/tc; state unchanged.
- Start handling:
  - Accepted start clears the prescaler and latches mode.
  - Direction initialises to down for mode 01, up otherwise.
  - Single-shot restart from DONE also sets code_out=0.
  - start while already in RUN is ignored.
- Prescaler:
  - Counts 0..DIV-1 only in RUN.
  - A step occurs in the cycle the prescaler equals DIV-1; the prescaler then wraps to 0.
  - First step after start therefore lands DIV cycles after the start edge.
  - Prescaler holds in IDLE/DONE.
- Step arithmetic (3-bit, modulo 8):
  - Wrap-up: 7->0, tc when the new value is 0.
  - Wrap-down: 0->7, tc when the new value is 7.
  - Ping-pong:
    - Going up, a step onto 7 flips direction to down, tc=1.
    - Going down, a step onto 0 flips direction to up, tc=1.
    - The next step moves away from the end (7,6,... / 0,1,...); end values are never repeated.
    - If loaded to 7 while going up, the next step flips direction and moves to 6; symmetric at 0.
  - Single-shot: increments; the step onto 7 asserts tc and enters DONE the following cycle; busy drops with it.
- Strobes:
  - step and tc are registered, asserted in the cycle code_out takes the new value, never longer than one cycle.
- stop: freezes code_out and direction; prescaler cleared so a later start gives a full DIV interval.
- mode changes while running have no effect.

Decomposition:
- Shared package:
  - Mode encodings MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_PING=2'b10, MODE_SHOT=2'b11.
  - State encodings IDLE/RUN/DONE.
  - CODE_W=3.
- One natural sub-module: step_prescaler (DIV counter with clear/enable, emits tick). All other logic stays in the top.

Test Plan:
1. Reset mid-run: DIV=4, mode 00, start, assert rst after code_out=3 -> code_out=0, busy=0, step=tc=0 immediately (async). Stays IDLE after release.
2. Wrap-up: DIV=4, mode 00, start -> code_out 0->1 four cycles after start, then every 4 cycles; 7->0 with step=1, tc=1 for one cycle.
3. Ping-pong: DIV=1, mode 10, start from 0 -> sequence 1,2,...,7,6,...,0,1. tc only on the 7 and 0 landings. No repeated end values.
4. Single-shot: DIV=2, mode 11 -> reaches 7, tc=1, then DONE, busy=0, code_out holds 7. Start again -> code_out=0, busy=1.
5. Load vs step collision: DIV=1, mode 00, code_out=2, load=1, load_val=5 -> next code_out=5, step=0, tc=0; following cycle 6.
6. start+stop same cycle in IDLE -> remains IDLE, code_out unchanged. In RUN, stop -> busy=0, code_out frozen; restart resumes from the frozen value after DIV cycles.

Source files
------------

// File: rtl/code_step_sequencer_pkg.sv
// Shared encodings for the code step sequencer: code width, sweep modes and control states.
package code_step_sequencer_pkg;

   localparam int CODE_W = 3;

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_PING = 2'b10,
      MODE_SHOT = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/code_step_sequencer_step_prescaler.sv
// Divide-by-DIV counter; tick_o is high during the last count of each interval while enabled.
module step_prescaler #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/code_step_sequencer.sv
// 3-bit code source for the encoder: steps the code every DIV clocks in wrap-up,
// wrap-down, ping-pong or single-shot mode, with load, start/stop and step/tc strobes.
module code_step_sequencer
   import code_step_sequencer_pkg::*;
#(
   parameter int DIV      = 4,
   parameter int CODE_MAX = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic [1:0]        mode,
   input  logic              load,
   input  logic [CODE_W-1:0] load_val,
   output logic [CODE_W-1:0] code_out,
   output logic              busy,
   output logic              step,
   output logic              tc
);

   localparam logic [CODE_W-1:0] TOP    = CODE_W'(CODE_MAX);
   localparam logic [CODE_W-1:0] TOP_M1 = TOP - 1'b1;
   localparam logic [CODE_W-1:0] BOT_P1 = CODE_W'(1);

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              dir_down_q, dir_down_d;
   logic              step_q, step_d;
   logic              tc_q, tc_d;

   logic tick;
   logic start_acc;
   logic do_step;
   logic presc_clr;

   // stop beats start; load beats a pending step and restarts the interval
   assign start_acc = start && !stop && (state_q != RUN);
   assign do_step   = tick && (state_q == RUN) && !stop && !load;
   assign presc_clr = load || stop || start_acc;

   step_prescaler #(.DIV(DIV)) u_prescaler (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (presc_clr),
      .en_i   (state_q == RUN),
      .tick_o (tick)
   );

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      code_d     = code_q;
      dir_down_d = dir_down_q;
      step_d     = 1'b0;
      tc_d       = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start_acc) begin
               state_d    = RUN;
               mode_d     = mode_e'(mode);
               dir_down_d = (mode_e'(mode) == MODE_DOWN);
               if ((state_q == DONE) && (mode_e'(mode) == MODE_SHOT)) begin
                  code_d = '0;
               end
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else if (do_step) begin
               step_d = 1'b1;
               case (mode_q)
                  MODE_UP: begin
                     code_d = code_q + 1'b1;
                     tc_d   = (code_q == TOP);
                  end
                  MODE_DOWN: begin
                     code_d = code_q - 1'b1;
                     tc_d   = (code_q == '0);
                  end
                  MODE_PING: begin
                     // an end value reached only by load turns around without repeating it
                     if (!dir_down_q) begin
                        if (code_q == TOP) begin
                           code_d     = TOP_M1;
                           dir_down_d = 1'b1;
                        end else begin
                           code_d = code_q + 1'b1;
                           if (code_q == TOP_M1) begin
                              dir_down_d = 1'b1;
                              tc_d       = 1'b1;
                           end
                        end
                     end else begin
                        if (code_q == '0) begin
                           code_d     = BOT_P1;
                           dir_down_d = 1'b0;
                        end else begin
                           code_d = code_q - 1'b1;
                           if (code_q == BOT_P1) begin
                              dir_down_d = 1'b0;
                              tc_d       = 1'b1;
                           end
                        end
                     end
                  end
                  MODE_SHOT: begin
                     code_d = code_q + 1'b1;
                     if (code_q == TOP_M1) begin
                        tc_d    = 1'b1;
                        state_d = DONE;
                     end
                  end
                  default: code_d = code_q;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         code_d = load_val;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         mode_q     <= MODE_UP;
         code_q     <= '0;
         dir_down_q <= 1'b0;
         step_q     <= 1'b0;
         tc_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         code_q     <= code_d;
         dir_down_q <= dir_down_d;
         step_q     <= step_d;
         tc_q       <= tc_d;
      end
   end

   assign code_out = code_q;
   assign busy     = (state_q == RUN);
   assign step     = step_q;
   assign tc       = tc_q;

endmodule

// File: tb/tb_code_step_sequencer.sv
// Directed bench for code_step_sequencer with DIV=4, DIV=1 and DIV=2 instances on shared inputs.
module tb_code_step_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       load = 1'b0;
   logic [2:0] load_val = 3'd0;

   logic [2:0] code4, code1, code2;
   logic       busy4, busy1, busy2;
   logic       step4, step1, step2;
   logic       tc4, tc1, tc2;

   int err_cnt = 0;
   int chk_cnt = 0;
   int pp [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

   always #5 clk = ~clk;

   code_step_sequencer #(.DIV(4), .CODE_MAX(7)) u_div4 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .load(load), .load_val(load_val),
      .code_out(code4), .busy(busy4), .step(step4), .tc(tc4)
   );

   code_step_sequencer #(.DIV(1), .CODE_MAX(7)) u_div1 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .load(load), .load_val(load_val),
      .code_out(code1), .busy(busy1), .step(step1), .tc(tc1)
   );

   code_step_sequencer #(.DIV(2), .CODE_MAX(7)) u_div2 (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
      .load(load), .load_val(load_val),
      .code_out(code2), .busy(busy2), .step(step2), .tc(tc2)
   );

   task automatic chk(input string tag, input int got, input int exp);
      chk_cnt++;
      if (got != exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s = %0d", tag, got);
      end
   endtask

   task automatic cy();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      start = 1'b0;
      stop  = 1'b0;
      load  = 1'b0;
      cy();
      cy();
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      // reset state
      cy();
      cy();
      chk("rst_code", int'(code4), 0);
      chk("rst_busy", int'(busy4), 0);
      chk("rst_step", int'(step4), 0);
      chk("rst_tc", int'(tc4), 0);
      rst = 1'b0;

      // wrap-up, DIV=4
      mode  = 2'b00;
      start = 1'b1;
      cy();
      start = 1'b0;
      chk("up_busy", int'(busy4), 1);
      chk("up_code0", int'(code4), 0);
      for (int k = 1; k <= 8; k++) begin
         repeat (3) cy();
         chk($sformatf("up_hold%0d", k), int'(code4), k - 1);
         chk($sformatf("up_nostep%0d", k), int'(step4), 0);
         cy();
         chk($sformatf("up_code%0d", k), int'(code4), k % 8);
         chk($sformatf("up_step%0d", k), int'(step4), 1);
         chk($sformatf("up_tc%0d", k), int'(tc4), int'(k == 8));
      end

      // asynchronous reset mid-run
      do_reset();
      mode  = 2'b00;
      start = 1'b1;
      cy();
      start = 1'b0;
      repeat (12) cy();
      chk("arst_pre_code", int'(code4), 3);
      chk("arst_pre_step", int'(step4), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_code", int'(code4), 0);
      chk("arst_busy", int'(busy4), 0);
      chk("arst_step", int'(step4), 0);
      chk("arst_tc", int'(tc4), 0);
      cy();
      rst = 1'b0;
      repeat (8) cy();
      chk("arst_idle_code", int'(code4), 0);
      chk("arst_idle_busy", int'(busy4), 0);

      // ping-pong, DIV=1
      do_reset();
      mode  = 2'b10;
      start = 1'b1;
      cy();
      start = 1'b0;
      chk("pp_busy", int'(busy1), 1);
      chk("pp_code0", int'(code1), 0);
      foreach (pp[i]) begin
         cy();
         chk($sformatf("pp_code%0d", i), int'(code1), pp[i]);
         chk($sformatf("pp_step%0d", i), int'(step1), 1);
         chk($sformatf("pp_tc%0d", i), int'(tc1), int'(pp[i] == 7 || pp[i] == 0));
      end

      // wrap-down, DIV=1: 0 -> 7 is terminal
      do_reset();
      mode  = 2'b01;
      start = 1'b1;
      cy();
      start = 1'b0;
      cy();
      chk("dn_code7", int'(code1), 7);
      chk("dn_tc7", int'(tc1), 1);
      cy();
      chk("dn_code6", int'(code1), 6);
      chk("dn_tc6", int'(tc1), 0);

      // single-shot, DIV=2
      do_reset();
      mode  = 2'b11;
      start = 1'b1;
      cy();
      start = 1'b0;
      chk("ss_busy", int'(busy2), 1);
      for (int v = 1; v <= 7; v++) begin
         cy();
         chk($sformatf("ss_hold%0d", v), int'(code2), v - 1);
         chk($sformatf("ss_nostep%0d", v), int'(step2), 0);
         cy();
         chk($sformatf("ss_code%0d", v), int'(code2), v);
         chk($sformatf("ss_step%0d", v), int'(step2), 1);
         chk($sformatf("ss_tc%0d", v), int'(tc2), int'(v == 7));
         chk($sformatf("ss_busy%0d", v), int'(busy2), int'(v != 7));
      end
      repeat (3) cy();
      chk("ss_done_code", int'(code2), 7);
      chk("ss_done_busy", int'(busy2), 0);
      chk("ss_done_step", int'(step2), 0);
      chk("ss_done_tc", int'(tc2), 0);
      start = 1'b1;
      cy();
      start = 1'b0;
      chk("ss_restart_code", int'(code2), 0);
      chk("ss_restart_busy", int'(busy2), 1);

      // load beats step, DIV=1
      do_reset();
      mode  = 2'b00;
      start = 1'b1;
      cy();
      start = 1'b0;
      cy();
      cy();
      chk("ld_pre_code", int'(code1), 2);
      load     = 1'b1;
      load_val = 3'd5;
      cy();
      load = 1'b0;
      chk("ld_code", int'(code1), 5);
      chk("ld_step", int'(step1), 0);
      chk("ld_tc", int'(tc1), 0);
      cy();
      chk("ld_next_code", int'(code1), 6);
      chk("ld_next_step", int'(step1), 1);

      // start+stop in IDLE, stop in RUN, resume, DIV=4
      do_reset();
      mode  = 2'b00;
      start = 1'b1;
      stop  = 1'b1;
      cy();
      start = 1'b0;
      stop  = 1'b0;
      chk("ss_idle_busy", int'(busy4), 0);
      repeat (4) cy();
      chk("ss_idle_code", int'(code4), 0);
      start = 1'b1;
      cy();
      start = 1'b0;
      chk("run_busy", int'(busy4), 1);
      repeat (4) cy();
      chk("run_code1", int'(code4), 1);
      chk("run_step1", int'(step4), 1);
      cy();
      start = 1'b1;
      stop  = 1'b1;
      cy();
      start = 1'b0;
      stop  = 1'b0;
      chk("stop_busy", int'(busy4), 0);
      chk("stop_code", int'(code4), 1);
      repeat (6) cy();
      chk("frozen_code", int'(code4), 1);
      chk("frozen_step", int'(step4), 0);
      start = 1'b1;
      cy();
      start = 1'b0;
      chk("resume_busy", int'(busy4), 1);
      repeat (3) cy();
      chk("resume_hold", int'(code4), 1);
      cy();
      chk("resume_code", int'(code4), 2);
      chk("resume_step", int'(step4), 1);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
